// File: rtl/telem_pkg.sv
// Shared state encoding, command codes and CRC helper for the telemetry framer.
package telem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        HDR,
        SEQ,
        DATA,
        CSUM
    } state_e;

    localparam logic [7:0] CMD_TRIG     = 8'h01;
    localparam logic [7:0] CMD_PER_ON   = 8'h02;
    localparam logic [7:0] CMD_PER_OFF  = 8'h03;
    localparam logic [7:0] CMD_CLR_DROP = 8'h04;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One byte of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
        logic [7:0] crc;
        crc = crc_in ^ data;
        for (int b = 0; b < 8; b++) begin
            crc = crc[7] ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
        end
        return crc;
    endfunction

endpackage

// File: rtl/telem_framer_if.sv
// Command (from uart_rx) and frame byte (to uart_tx) valid/ready streams of the framer.
interface telem_framer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;

    modport master (
        input  cmd_valid, cmd_byte, tx_ready,
        output cmd_ready, tx_valid, tx_byte
    );

    modport slave (
        output cmd_valid, cmd_byte, tx_ready,
        input  cmd_ready, tx_valid, tx_byte
    );

endinterface

// File: rtl/telem_chk.sv
// Byte-wise frame check accumulator; result_c already includes the byte being accepted.
// Build macro TELEM_CRC8_EN selects CRC-8 instead of the two's-complement byte sum.
module telem_chk
    import telem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] data_in,
    output logic [7:0] result_c
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (byte_en) begin
`ifdef TELEM_CRC8_EN
            acc_d = crc8_byte(acc_q, data_in);
`else
            acc_d = acc_q + data_in;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef TELEM_CRC8_EN
    assign result_c = acc_d;
`else
    assign result_c = ~acc_d + 8'd1;
`endif

endmodule

// File: rtl/telem_framer.sv
// Telemetry framer: snapshots NUM_CH channels and streams HEADER, seq, channel bytes, check byte.
// Build macro TELEM_CRC8_EN (handled in telem_chk) turns the check byte into a CRC-8.
module telem_framer
    import telem_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CH_W         = 8,
    parameter int unsigned PERIOD_CLKS  = 5_000_000,
    parameter logic [7:0]  HEADER       = 8'hA5,
    parameter logic        PERIODIC_RST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    telem_framer_if.master           bus,
    output logic                     busy,
    output logic                     periodic_en,
    output logic [7:0]               seq_num,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned DATA_W = NUM_CH * CH_W;
    localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W  = $clog2(PERIOD_CLKS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CLKS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic [7:0]        seq_q, seq_d;
    logic              pending_q, pending_d;
    logic              per_en_q, per_en_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        drop_q, drop_d;

    logic              xfer_c;
    logic              cmd_acc_c;
    logic              trig_c;
    logic              consume_c;
    logic              chk_clr_c;
    logic              chk_en_c;
    logic [7:0]        chk_c;

    // Zero-extended channel byte from the snapshot.
    function automatic logic [7:0] ch_byte(input logic [DATA_W-1:0] snap, input logic [IDX_W-1:0] sel);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (IDX_W'(i) == sel) begin
                b = 8'(snap[i*CH_W +: CH_W]);
            end
        end
        return b;
    endfunction

    assign xfer_c    = tx_valid_q && bus.tx_ready;
    assign cmd_acc_c = bus.cmd_valid && cmd_ready_q;
    assign trig_c    = (cmd_acc_c && (bus.cmd_byte == CMD_TRIG)) || (per_en_q && (cnt_q == CNT_LAST));
    assign consume_c = (state_q == IDLE) && pending_q;
    assign chk_clr_c = (state_q == SNAP);
    assign chk_en_c  = xfer_c && ((state_q == SEQ) || (state_q == DATA));

    telem_chk u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (chk_clr_c),
        .byte_en  (chk_en_c),
        .data_in  (tx_byte_q),
        .result_c (chk_c)
    );

    // Commands, periodic timer and trigger coalescing.
    always_comb begin
        per_en_d    = per_en_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        pending_d   = pending_q;
        cmd_ready_d = 1'b1;

        if (per_en_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        if (cmd_acc_c) begin
            case (bus.cmd_byte)
                CMD_PER_ON:  per_en_d = 1'b1;
                CMD_PER_OFF: begin
                    per_en_d = 1'b0;
                    cnt_d    = '0;
                end
                default: ;
            endcase
        end

        if (consume_c) begin
            pending_d = 1'b0;
        end
        if (trig_c) begin
            pending_d = 1'b1;
            if (pending_q && !consume_c && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
        end
        if (cmd_acc_c && (bus.cmd_byte == CMD_CLR_DROP)) begin
            drop_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pending_q) state_d = SNAP;
            SNAP: state_d = HDR;
            HDR:  if (xfer_c) state_d = SEQ;
            SEQ:  if (xfer_c) state_d = DATA;
            DATA: if (xfer_c && (idx_q == IDX_LAST)) state_d = CSUM;
            CSUM: if (xfer_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next byte is loaded on the transfer edge so the stream stays back-to-back.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        seq_d      = seq_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        case (state_q)
            SNAP: begin
                snap_d     = ch_data;
                idx_d      = '0;
                busy_d     = 1'b1;
                tx_valid_d = 1'b1;
                tx_byte_d  = HEADER;
            end
            HDR: if (xfer_c) tx_byte_d = seq_q;
            SEQ: if (xfer_c) tx_byte_d = ch_byte(snap_q, '0);
            DATA: if (xfer_c) begin
                if (idx_q == IDX_LAST) begin
                    tx_byte_d = chk_c;
                end else begin
                    idx_d     = idx_q + IDX_W'(1);
                    tx_byte_d = ch_byte(snap_q, idx_q + IDX_W'(1));
                end
            end
            CSUM: if (xfer_c) begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                seq_d      = seq_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            snap_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
            seq_q       <= '0;
            pending_q   <= 1'b0;
            per_en_q    <= PERIODIC_RST;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= '0;
        end else begin
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= busy_d;
            seq_q       <= seq_d;
            pending_q   <= pending_d;
            per_en_q    <= per_en_d;
            cmd_ready_q <= cmd_ready_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_byte   = tx_byte_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign busy          = busy_q;
    assign periodic_en   = per_en_q;
    assign seq_num       = seq_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_telem_framer.sv
// Directed/randomised bench for telem_framer with a frame-level reference model.
module tb_telem_framer;
    import telem_pkg::*;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CH_W   = 8;
    localparam int unsigned DW     = NUM_CH * CH_W;
    localparam int unsigned PER    = 100;
    localparam int unsigned FLEN   = NUM_CH + 3;
`ifdef TELEM_CRC8_EN
    localparam logic [7:0] S1_LAST = 8'hF1;
`else
    localparam logic [7:0] S1_LAST = 8'hBA;
`endif

    typedef logic [7:0] frame_t [FLEN];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ch_data = '0;
    logic          busy;
    logic          periodic_en;
    logic [7:0]    seq_num;
    logic [7:0]    drop_cnt;

    int          total = 0;
    int          bad = 0;
    int          exp_seq = 0;
    int unsigned cyc = 0;

    telem_framer_if bus ();

    telem_framer #(
        .NUM_CH       (NUM_CH),
        .CH_W         (CH_W),
        .PERIOD_CLKS  (PER),
        .HEADER       (8'hA5),
        .PERIODIC_RST (1'b0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data     (ch_data),
        .bus         (bus),
        .busy        (busy),
        .periodic_en (periodic_en),
        .seq_num     (seq_num),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] code, output int unsigned at);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = code;
        at = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // Frame = header, seq, channels, check byte over seq+channels.
    function automatic void model(input int seq, input logic [DW-1:0] ch, output frame_t f);
        int         sum;
        logic [7:0] crc;
        sum = 0;
        crc = 8'h00;
        f[0] = 8'hA5;
        f[1] = 8'(seq);
        for (int c = 0; c < NUM_CH; c++) f[2+c] = 8'(ch[c*CH_W +: CH_W]);
        for (int i = 1; i < FLEN - 1; i++) begin
            sum += int'(f[i]);
            crc = crc_ref(crc, f[i]);
        end
`ifdef TELEM_CRC8_EN
        f[FLEN-1] = crc;
`else
        f[FLEN-1] = 8'((256 - (sum % 256)) % 256);
`endif
    endfunction

    task automatic wait_valid(input int budget, input string tag, output int unsigned t);
        int n;
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("%s valid_rise", tag), 32'(bus.tx_valid), 32'd1);
        t = cyc;
    endtask

    // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
    task automatic run_frame(input int mode, input frame_t f, input bit scramble, input string tag);
        int         got;
        int         n;
        logic [7:0] held;
        bit         stalled;
        bit         rdy;
        got = 0;
        n = 0;
        held = '0;
        stalled = 1'b0;
        while (got < int'(FLEN) && n < 400) begin
            check($sformatf("%s valid", tag), 32'(bus.tx_valid), 32'd1);
            if (stalled) check($sformatf("%s hold", tag), 32'(bus.tx_byte), 32'(held));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.tx_ready = rdy;
            if (rdy) begin
                check($sformatf("%s byte%0d", tag, got), 32'(bus.tx_byte), 32'(f[got]));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = bus.tx_byte;
            end
            if (scramble) ch_data = DW'($urandom);
            tick();
            n++;
        end
        bus.tx_ready = 1'b0;
        check($sformatf("%s count", tag), 32'(got), 32'(FLEN));
        check($sformatf("%s end_valid", tag), 32'(bus.tx_valid), 32'd0);
        check($sformatf("%s end_busy", tag), 32'(busy), 32'd0);
        exp_seq = (exp_seq + 1) % 256;
        check($sformatf("%s seq_num", tag), 32'(seq_num), 32'(exp_seq));
    endtask

    initial begin
        int unsigned t0, t1, t2;
        frame_t      f, f2;
        bit          seen;

        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        bus.tx_ready  = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst tx_byte", 32'(bus.tx_byte), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst seq", 32'(seq_num), 32'd0);
        check("rst drop", 32'(drop_cnt), 32'd0);
        check("rst per_en", 32'(periodic_en), 32'd0);
        check("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        rst_n = 1'b1;
        tick();
        check("cmd_ready up", 32'(bus.cmd_ready), 32'd1);

        // Basic frame with fixed channels and known check byte.
        ch_data = 16'h3412;
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "s1", t1);
        check("s1 latency", t1 - t0, 32'd3);
        f = '{8'hA5, 8'h00, 8'h12, 8'h34, S1_LAST};
        run_frame(0, f, 1'b0, "s1");

        // Same data under 1-of-3 back-pressure.
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "s2", t1);
        model(exp_seq, ch_data, f);
        run_frame(1, f, 1'b0, "s2");

        // Random channels, random ready, inputs scrambled after the snapshot.
        for (int k = 0; k < 6; k++) begin
            ch_data = DW'($urandom);
            send_cmd(CMD_TRIG, t0);
            wait_valid(10, "rnd", t1);
            model(exp_seq, ch_data, f);
            run_frame(2, f, 1'b1, $sformatf("rnd%0d", k));
        end

        // Unknown command does nothing.
        send_cmd(8'h55, t0);
        repeat (8) tick();
        check("ign valid", 32'(bus.tx_valid), 32'd0);
        check("ign busy", 32'(busy), 32'd0);
        check("ign per_en", 32'(periodic_en), 32'd0);
        check("ign drop", 32'(drop_cnt), 32'd0);

        // Three triggers during a stalled frame: one follow-up, two drops.
        ch_data = DW'($urandom);
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "drop", t1);
        model(exp_seq, ch_data, f);
        repeat (3) send_cmd(CMD_TRIG, t1);
        check("drop cnt2", 32'(drop_cnt), 32'd2);
        run_frame(0, f, 1'b0, "drop_a");
        model(exp_seq, ch_data, f2);
        wait_valid(10, "drop_b", t1);
        run_frame(0, f2, 1'b0, "drop_b");
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.tx_valid) seen = 1'b1;
        end
        check("drop no_third", 32'(seen), 32'd0);
        check("drop cnt_hold", 32'(drop_cnt), 32'd2);
        send_cmd(CMD_CLR_DROP, t0);
        check("drop clr", 32'(drop_cnt), 32'd0);

        // Periodic triggering.
        send_cmd(CMD_PER_ON, t0);
        check("per on", 32'(periodic_en), 32'd1);
        wait_valid(int'(PER) + 20, "per0", t1);
        check("per first", t1 - t0, 32'(PER + 3));
        model(exp_seq, ch_data, f);
        run_frame(0, f, 1'b0, "per0");
        wait_valid(int'(PER) + 20, "per1", t2);
        check("per spacing", t2 - t1, 32'(PER));
        model(exp_seq, ch_data, f);
        run_frame(0, f, 1'b0, "per1");
        send_cmd(CMD_PER_OFF, t0);
        check("per off", 32'(periodic_en), 32'd0);
        seen = 1'b0;
        repeat (2 * PER) begin
            tick();
            if (bus.tx_valid) seen = 1'b1;
        end
        check("per off quiet", 32'(seen), 32'd0);

        // Run until the sequence number wraps, then the 257th frame carries 00.
        while (exp_seq != 0) begin
            ch_data = DW'($urandom);
            send_cmd(CMD_TRIG, t0);
            wait_valid(10, "wrap", t1);
            model(exp_seq, ch_data, f);
            run_frame(0, f, 1'b0, $sformatf("wrap%0d", exp_seq));
        end
        ch_data = DW'($urandom);
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "wrap257", t1);
        check("wrap257 seq_byte_src", 32'(seq_num), 32'd0);
        model(exp_seq, ch_data, f);
        run_frame(2, f, 1'b0, "wrap257");

        // Reset in the middle of the data bytes.
        ch_data = DW'($urandom);
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "mrst", t1);
        model(exp_seq, ch_data, f);
        bus.tx_ready = 1'b1;
        tick();
        tick();
        check("mrst data0", 32'(bus.tx_byte), 32'(f[2]));
        bus.tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mrst tx_valid", 32'(bus.tx_valid), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst seq", 32'(seq_num), 32'd0);
        tick();
        rst_n = 1'b1;
        exp_seq = 0;
        tick();
        ch_data = DW'($urandom);
        send_cmd(CMD_TRIG, t0);
        wait_valid(10, "post_rst", t1);
        check("post_rst latency", t1 - t0, 32'd3);
        model(exp_seq, ch_data, f);
        run_frame(0, f, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
